par_bus_ctrl: RTL and testbench
===============================

// Module: par_bus_ctrl
// PURPOSE
//  Controller for the RPI parallel bus (bus_clk / bus_data / bus_rnw), used by every FPGA-side consumer.
//  Synchronises the bus into clk_100mhz and detects RPI strobes. Owns the bidirectional data pin and its direction.
//  RPI writes are delivered as a byte stream; RPI reads are fed from a valid/ready byte source.
//  Counts bytes transferred in each direction and flags overrun and underrun errors.
// PARAMETERS
//  SYNC_STAGES  2   flops in the bus_clk/bus_rnw/bus_data synchroniser chains (>=2)
//  CNT_W        16  width of the byte counters
// PORTS
//  clk_100mhz  in     1      system clock
//  reset_n     in     1      asynchronous reset, active-low
//  bus_clk     in     1      RPI strobe; async; data valid at rising edge
//  bus_data    inout  8      RPI data bus
//  bus_rnw     in     1      1 = RPI read (FPGA drives), 0 = RPI write
//  rx_data     out    8      byte received from RPI
//  rx_valid    out    1      1-cycle pulse, rx_data valid
//  rx_ready    in     1      consumer can accept; sampled when rx_valid pulses
//  tx_data     in     8      next byte for RPI reads
//  tx_valid    in     1      tx_data valid
//  tx_ready    out    1      1-cycle pulse: tx_data taken (valid&ready handshake)
//  clear       in     1      sync clear of counters and sticky flags
//  rx_count    out    CNT_W  bytes written by RPI, wraps
//  tx_count    out    CNT_W  bytes read by RPI, wraps
//  rx_overrun  out    1      sticky: byte arrived with rx_ready=0
//  tx_underrun out    1      sticky: RPI strobed a read with no byte loaded
//  bus_dir     out    1      1 = FPGA drive enabled (registered)
// BEHAVIOUR
//  Reset (async, reset_n=0): every output 0, bus_data Z immediately, state IDLE, tx holding byte 0x00.
//  Sync: bus_clk, bus_rnw, bus_data through SYNC_STAGES flops. Strobe = synced bus_clk 0->1.
//  Direction of a strobe = synced rnw in the same stage as the edge.
//  States: IDLE, WRITE, RD_FETCH, RD_HOLD.
//  IDLE: synced rnw=0 -> WRITE. Synced rnw=1 -> RD_FETCH.
//  WRITE: on a strobe, rx_data <= synced data and rx_valid pulses on the next cycle (latency SYNC_STAGES+1 from pin edge).
//    rx_count++ on the same strobe. If rx_ready=0 at the pulse, rx_overrun <= 1; the byte is still presented, no backpressure.
//    Synced rnw=1 -> RD_FETCH.
//  RD_FETCH: combinational tx_ready = tx_valid.
//    On handshake, hold <= tx_data and go to RD_HOLD. Holding byte 0x00 while fetching.
//    Strobe in RD_FETCH without handshake: tx_underrun <= 1, tx_count++, stay in RD_FETCH.
//    Handshake and strobe in the same cycle: strobe counts as underrun; the new byte is held for the next strobe.
//  RD_HOLD: a strobe consumes the byte: tx_count++, go to RD_FETCH. Synced rnw=0 -> WRITE; held byte kept.
//  Drive: bus_dir = 1 in RD_FETCH/RD_HOLD.
//    Pin enable = bus_dir & raw bus_rnw (combinational), so the pin releases the same cycle RPI drops rnw.
//  Driven value = holding register.
//  Counters: CNT_W bits, wrap from all-ones to 0 silently.
//    clear wins over a same-cycle increment or flag set.
//  Reset mid-transfer aborts: a partially sampled byte is lost and not counted.
// STRUCTURE
//  par_bus_pkg.vh: state localparams, BUS_W=8, direction encodings. Shared with other bus-side blocks.
//  Sub-module sync_edge: SYNC_STAGES synchroniser with rising-edge pulse output. One instance for bus_clk.
//    Plain synchroniser chains for rnw and data.
//  Top holds the FSM, holding register, counters, flags and tri-state assign.
// TESTING
//  RPI writes 0..255 sequentially, rx_ready=1 -> 256 rx_valid pulses carrying 0..255 in order.
//    rx_count=256, rx_overrun=0.
//  Write burst with rx_ready=0 during byte 5 -> rx_overrun=1 after byte 5.
//    rx_count still increments, byte 6 delivered normally.
//  tx source offers 0xA5 then 0x5A, RPI performs 2 reads -> RPI samples 0xA5, 0x5A.
//    tx_ready pulses twice, tx_count=2.
//  tx_valid=0, RPI strobes one read -> RPI samples 0x00, tx_underrun=1, tx_count=1.
//  RPI drops bus_rnw while FPGA drives -> bus_data Z in the same cycle, bus_dir=0 after sync, state WRITE.
//  reset_n low mid-read -> bus_data Z and all outputs 0 without a clock.
//    clear coincident with a write strobe -> rx_count=0.

Source files
------------

// File: rtl/par_bus_pkg.sv
// Shared definitions for the RPI parallel-bus blocks: bus width, controller
// states and pin direction encodings.
package par_bus_pkg;

   localparam int BUS_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WRITE    = 2'd1,
      ST_RD_FETCH = 2'd2,
      ST_RD_HOLD  = 2'd3
   } bus_state_e;

   localparam logic DIR_IN  = 1'b0;
   localparam logic DIR_OUT = 1'b1;

   function automatic logic is_drive_state(bus_state_e s);
      return (s == ST_RD_FETCH) || (s == ST_RD_HOLD);
   endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for one asynchronous bit with a single-cycle pulse
// on each synchronised 0->1 transition.
module sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic rise_o
);

   logic [STAGES-1:0] chain_q;
   logic              prev_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         chain_q <= '0;
         prev_q  <= 1'b0;
      end else begin
         chain_q <= {chain_q[STAGES-2:0], d_i};
         prev_q  <= chain_q[STAGES-1];
      end
   end

   // Combinational so the pulse lines up with the rnw/data chains of equal depth
   assign rise_o = chain_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/par_bus_ctrl.sv
// RPI parallel-bus controller: synchronises the bus, turns write strobes into
// a byte stream, serves read strobes from a valid/ready source, owns the pin.
module par_bus_ctrl
   import par_bus_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16
) (
   input  logic             clk_100mhz,
   input  logic             reset_n,
   input  logic             bus_clk,
   inout  wire  [BUS_W-1:0] bus_data,
   input  logic             bus_rnw,
   output logic [BUS_W-1:0] rx_data,
   output logic             rx_valid,
   input  logic             rx_ready,
   input  logic [BUS_W-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   input  logic             clear,
   output logic [CNT_W-1:0] rx_count,
   output logic [CNT_W-1:0] tx_count,
   output logic             rx_overrun,
   output logic             tx_underrun,
   output logic             bus_dir
);

   logic                              strobe;
   logic [SYNC_STAGES-1:0][BUS_W:0]   pipe_q;
   logic                              rnw_s;
   logic [BUS_W-1:0]                  data_s;

   bus_state_e       state_q,       state_d;
   logic [BUS_W-1:0] hold_q,        hold_d;
   logic             hold_full_q,   hold_full_d;
   logic [BUS_W-1:0] rx_data_q,     rx_data_d;
   logic             rx_valid_q,    rx_valid_d;
   logic [CNT_W-1:0] rx_count_q,    rx_count_d;
   logic [CNT_W-1:0] tx_count_q,    tx_count_d;
   logic             rx_overrun_q,  rx_overrun_d;
   logic             tx_underrun_q, tx_underrun_d;
   logic             bus_dir_q,     bus_dir_d;
   logic             rx_inc, tx_inc, ovr_set, und_set;

   sync_edge #(
      .STAGES (SYNC_STAGES)
   ) u_clk_sync (
      .clk_i  (clk_100mhz),
      .rst_ni (reset_n),
      .d_i    (bus_clk),
      .rise_o (strobe)
   );

   always_ff @(posedge clk_100mhz or negedge reset_n) begin
      if (!reset_n) begin
         pipe_q <= '0;
      end else begin
         pipe_q <= {pipe_q[SYNC_STAGES-2:0], {bus_rnw, bus_data}};
      end
   end

   assign rnw_s  = pipe_q[SYNC_STAGES-1][BUS_W];
   assign data_s = pipe_q[SYNC_STAGES-1][BUS_W-1:0];

   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      rx_inc      = 1'b0;
      tx_inc      = 1'b0;
      und_set     = 1'b0;
      tx_ready    = 1'b0;
      ovr_set     = rx_valid_q & ~rx_ready;

      case (state_q)
         ST_IDLE: begin
            state_d = rnw_s ? ST_RD_FETCH : ST_WRITE;
         end
         ST_WRITE: begin
            // A byte loaded before a write burst is still owed to the next read
            if (rnw_s) begin
               state_d = hold_full_q ? ST_RD_HOLD : ST_RD_FETCH;
            end else if (strobe) begin
               rx_data_d  = data_s;
               rx_valid_d = 1'b1;
               rx_inc     = 1'b1;
            end
         end
         ST_RD_FETCH: begin
            tx_ready = tx_valid;
            if (tx_valid) begin
               hold_d      = tx_data;
               hold_full_d = 1'b1;
            end
            // The pin still showed 0x00 when the RPI sampled, so a coincident
            // handshake does not rescue this strobe.
            if (strobe && rnw_s) begin
               und_set = 1'b1;
               tx_inc  = 1'b1;
            end
            if (!rnw_s) begin
               state_d = ST_WRITE;
            end else if (tx_valid) begin
               state_d = ST_RD_HOLD;
            end
         end
         ST_RD_HOLD: begin
            if (!rnw_s) begin
               state_d = ST_WRITE;
            end else if (strobe) begin
               tx_inc      = 1'b1;
               hold_d      = '0;
               hold_full_d = 1'b0;
               state_d     = ST_RD_FETCH;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      rx_count_d    = clear ? '0 : rx_count_q + {{(CNT_W-1){1'b0}}, rx_inc};
      tx_count_d    = clear ? '0 : tx_count_q + {{(CNT_W-1){1'b0}}, tx_inc};
      rx_overrun_d  = clear ? 1'b0 : (rx_overrun_q | ovr_set);
      tx_underrun_d = clear ? 1'b0 : (tx_underrun_q | und_set);
      bus_dir_d     = is_drive_state(state_d) ? DIR_OUT : DIR_IN;
   end

   always_ff @(posedge clk_100mhz or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         hold_q        <= '0;
         hold_full_q   <= 1'b0;
         rx_data_q     <= '0;
         rx_valid_q    <= 1'b0;
         rx_count_q    <= '0;
         tx_count_q    <= '0;
         rx_overrun_q  <= 1'b0;
         tx_underrun_q <= 1'b0;
         bus_dir_q     <= DIR_IN;
      end else begin
         state_q       <= state_d;
         hold_q        <= hold_d;
         hold_full_q   <= hold_full_d;
         rx_data_q     <= rx_data_d;
         rx_valid_q    <= rx_valid_d;
         rx_count_q    <= rx_count_d;
         tx_count_q    <= tx_count_d;
         rx_overrun_q  <= rx_overrun_d;
         tx_underrun_q <= tx_underrun_d;
         bus_dir_q     <= bus_dir_d;
      end
   end

   // Raw rnw gates the driver so the pin lets go as soon as the RPI turns the bus
   assign bus_data = (bus_dir_q && bus_rnw) ? hold_q : {BUS_W{1'bz}};

   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign rx_count    = rx_count_q;
   assign tx_count    = tx_count_q;
   assign rx_overrun  = rx_overrun_q;
   assign tx_underrun = tx_underrun_q;
   assign bus_dir     = bus_dir_q;

endmodule

// File: tb/tb_par_bus_ctrl.sv
// Scoreboard bench for par_bus_ctrl: stimulus pushes expected bytes, monitors
// pop them when rx_valid pulses or when the RPI samples a read.
module tb_par_bus_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        bus_clk;
   logic        bus_rnw;
   wire  [7:0]  bus_data;
   logic        tb_drive;
   logic [7:0]  tb_wdata;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        clear;
   logic [15:0] rx_count;
   logic [15:0] tx_count;
   logic        rx_overrun;
   logic        tx_underrun;
   logic        bus_dir;

   int errors = 0;
   int checks = 0;
   int tx_pulses = 0;
   logic [7:0] exp_rx[$];
   logic [7:0] exp_rd[$];

   always #5 clk = ~clk;

   // A released bus reads 0xFF through the pull-ups
   assign bus_data = tb_drive ? tb_wdata : 8'bzzzzzzzz;
   for (genvar gi = 0; gi < 8; gi++) begin : g_pu
      pullup pu (bus_data[gi]);
   end

   par_bus_ctrl #(
      .SYNC_STAGES (2),
      .CNT_W       (16)
   ) dut (
      .clk_100mhz  (clk),
      .reset_n     (reset_n),
      .bus_clk     (bus_clk),
      .bus_data    (bus_data),
      .bus_rnw     (bus_rnw),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .clear       (clear),
      .rx_count    (rx_count),
      .tx_count    (tx_count),
      .rx_overrun  (rx_overrun),
      .tx_underrun (tx_underrun),
      .bus_dir     (bus_dir)
   );

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
      end else begin
         $display("ok   %s = %0h", name, act);
      end
   endtask

   // Monitor: bytes delivered to the consumer
   always @(negedge clk) begin
      if (rx_valid) begin
         checks++;
         if (exp_rx.size() == 0) begin
            errors++;
            $display("FAIL rx_unexpected: got=%02h expected=none", rx_data);
         end else begin
            logic [7:0] e;
            e = exp_rx.pop_front();
            if (rx_data !== e) begin
               errors++;
               $display("FAIL rx_byte: got=%02h expected=%02h", rx_data, e);
            end else begin
               $display("rx   byte=%02h", rx_data);
            end
         end
      end
      if (tx_ready) tx_pulses++;
   end

   // Monitor: what the RPI samples on a read strobe
   always @(posedge bus_clk) begin
      if (bus_rnw) begin
         checks++;
         if (exp_rd.size() == 0) begin
            errors++;
            $display("FAIL rd_unexpected: got=%02h expected=none", bus_data);
         end else begin
            logic [7:0] e;
            e = exp_rd.pop_front();
            if (bus_data !== e) begin
               errors++;
               $display("FAIL rd_byte: got=%02h expected=%02h", bus_data, e);
            end else begin
               $display("rd   byte=%02h", bus_data);
            end
         end
      end
   end

   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rpi_write(logic [7:0] b);
      exp_rx.push_back(b);
      tb_wdata = b;
      tick(2);
      bus_clk = 1'b1;
      tick(4);
      bus_clk = 1'b0;
      tick(4);
   endtask

   task automatic rpi_read(logic [7:0] b);
      exp_rd.push_back(b);
      tick(2);
      bus_clk = 1'b1;
      tick(4);
      bus_clk = 1'b0;
      tick(4);
   endtask

   task automatic tx_offer(logic [7:0] b);
      int n;
      n = 0;
      tx_data  = b;
      tx_valid = 1'b1;
      while (n < 20) begin
         @(negedge clk);
         if (tx_ready) break;
         n++;
      end
      if (n >= 20) begin
         checks++;
         errors++;
         $display("FAIL tx_handshake: got=timeout expected=tx_ready");
      end
      @(posedge clk);
      #1 tx_valid = 1'b0;
   endtask

   initial begin
      reset_n  = 1'b0;
      bus_clk  = 1'b0;
      bus_rnw  = 1'b0;
      tb_drive = 1'b0;
      tb_wdata = 8'h00;
      rx_ready = 1'b1;
      tx_data  = 8'h00;
      tx_valid = 1'b0;
      clear    = 1'b0;
      #2;
      check("reset_bus_data_released", 32'(bus_data), 32'hFF);
      check("reset_bus_dir", 32'(bus_dir), 0);
      check("reset_rx_valid", 32'(rx_valid), 0);
      check("reset_tx_ready", 32'(tx_ready), 0);
      check("reset_rx_count", 32'(rx_count), 0);
      check("reset_tx_count", 32'(tx_count), 0);
      tick(3);
      reset_n  = 1'b1;
      tb_drive = 1'b1;
      tick(3);

      for (int i = 0; i < 256; i++) rpi_write(8'(i));
      check("seq_rx_count", 32'(rx_count), 32'd256);
      check("seq_rx_overrun", 32'(rx_overrun), 0);

      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      check("clear_rx_count", 32'(rx_count), 0);

      for (int i = 1; i <= 7; i++) begin
         if (i == 5) rx_ready = 1'b0;
         rpi_write(8'(8'h10 + i));
         rx_ready = 1'b1;
         if (i == 4) check("overrun_before_b5", 32'(rx_overrun), 0);
         if (i == 5) check("overrun_after_b5", 32'(rx_overrun), 1);
      end
      check("burst_rx_count", 32'(rx_count), 32'd7);

      tb_drive = 1'b0;
      bus_rnw  = 1'b1;
      tick(4);
      check("read_bus_dir", 32'(bus_dir), 1);
      tx_offer(8'hA5);
      rpi_read(8'hA5);
      tx_offer(8'h5A);
      rpi_read(8'h5A);
      check("read_tx_count", 32'(tx_count), 32'd2);
      check("read_tx_ready_pulses", 32'(tx_pulses), 32'd2);
      check("read_tx_underrun", 32'(tx_underrun), 0);

      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      rpi_read(8'h00);
      check("underrun_flag", 32'(tx_underrun), 1);
      check("underrun_tx_count", 32'(tx_count), 32'd1);

      @(negedge clk);
      check("drive_before_drop", 32'(bus_data), 32'h00);
      #2 bus_rnw = 1'b0;
      #1;
      check("drop_release_same_cycle", 32'(bus_data), 32'hFF);
      check("drop_bus_dir_registered", 32'(bus_dir), 1);
      tick(4);
      check("drop_bus_dir_after_sync", 32'(bus_dir), 0);
      tb_drive = 1'b1;
      rpi_write(8'h77);
      check("drop_write_rx_count", 32'(rx_count), 32'd1);

      exp_rx.push_back(8'h88);
      tb_wdata = 8'h88;
      tick(2);
      bus_clk = 1'b1;
      clear   = 1'b1;
      tick(4);
      clear   = 1'b0;
      bus_clk = 1'b0;
      tick(4);
      check("clear_vs_strobe_rx_count", 32'(rx_count), 0);

      tb_drive = 1'b0;
      bus_rnw  = 1'b1;
      tick(4);
      tx_offer(8'h3C);
      rpi_read(8'h3C);
      tx_offer(8'hC3);
      tick(1);
      check("midread_bus_data", 32'(bus_data), 32'hC3);
      check("midread_tx_count", 32'(tx_count), 32'd1);
      check("midread_rx_data", 32'(rx_data), 32'h88);
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("arst_bus_data_released", 32'(bus_data), 32'hFF);
      check("arst_bus_dir", 32'(bus_dir), 0);
      check("arst_rx_data", 32'(rx_data), 0);
      check("arst_tx_count", 32'(tx_count), 0);
      check("arst_rx_count", 32'(rx_count), 0);
      check("arst_flags", {30'd0, rx_overrun, tx_underrun}, 0);
      check("arst_tx_ready", 32'(tx_ready), 0);
      bus_rnw = 1'b0;
      tick(2);
      reset_n = 1'b1;
      tick(3);

      check("rx_queue_drained", 32'(exp_rx.size()), 0);
      check("rd_queue_drained", 32'(exp_rd.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
